db15_serial_joy_reader: RTL and testbench

- Polls the two-player serial DB15 joystick adapter on the user port. The adapter is a 74HC165-style parallel-load shift-register chain.
- Produces two debounced, active-high 16-bit joystick words for the core top level. The top level ORs these into its player-1/player-2 control paths.
- Drives the adapter's JOY_CLK and JOY_LOAD lines and samples JOY_DATA.
- Sits directly upstream of the top-level joystick multiplexing.

---
 rtl/db15_serial_joy_reader.sv | 142 ++++++++++++++
 tb/tb_db15_serial_joy_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/db15_serial_joy_reader.sv
// Poller for the two-player serial DB15 adapter (74HC165 chain on the user port).
// Produces debounced active-high joystick words; a word updates only after two identical frames.
module db15_serial_joy_reader #(
    parameter int CLK_DIV    = 8,
    parameter int POLL_TICKS = 256,
    parameter int FRAME_BITS = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(POLL_TICKS + 1);
    localparam int BW = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {IDLE, LOAD, SAMPLE, CLKHI, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         div_q, div_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] prev_q, prev_d;
    logic [1:0]            sync_q, sync_d;
    logic                  jclk_q, jclk_d;
    logic                  load_q, load_d;
    logic [15:0]           j1_q, j1_d;
    logic [15:0]           j2_q, j2_d;
    logic                  tick;

    assign tick = (div_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            idle_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            prev_q  <= '1;
            sync_q  <= '1;
            jclk_q  <= 1'b0;
            load_q  <= 1'b1;
            j1_q    <= '0;
            j2_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idle_q  <= idle_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            sync_q  <= sync_d;
            jclk_q  <= jclk_d;
            load_q  <= load_d;
            j1_q    <= j1_d;
            j2_q    <= j2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        idle_d  = idle_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        prev_d  = prev_q;
        sync_d  = {sync_q[0], JOY_DATA};
        jclk_d  = jclk_q;
        load_d  = load_q;
        j1_d    = j1_q;
        j2_d    = j2_q;
        case (state_q)
            IDLE: begin
                load_d = 1'b1;
                jclk_d = 1'b0;
                if (!en) begin
                    idle_d = '0;
                    j1_d   = '0;
                    j2_d   = '0;
                    prev_d = '1;
                end else if (tick) begin
                    if (idle_q == IW'(POLL_TICKS - 1)) begin
                        idle_d  = '0;
                        load_d  = 1'b0;
                        state_d = LOAD;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                if (tick) begin
                    load_d  = 1'b1;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                jclk_d = 1'b0;
                // Sample at the end of the low half so data has settled through the synchronizer.
                if (tick) begin
                    shift_d[bit_q] = sync_q[1];
                    jclk_d         = 1'b1;
                    state_d        = CLKHI;
                end
            end
            CLKHI: begin
                if (tick) begin
                    jclk_d = 1'b0;
                    if (bit_q == BW'(FRAME_BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = SAMPLE;
                    end
                end
            end
            DONE: begin
                bit_d = '0;
                if (shift_q == prev_q) begin
                    j1_d = {4'b0, ~shift_q[11:0]};
                    j2_d = {4'b0, ~shift_q[23:12]};
                end
                prev_d  = shift_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign JOY_CLK    = jclk_q;
    assign JOY_LOAD   = load_q;
    assign joystick1  = j1_q;
    assign joystick2  = j2_q;
    assign frame_done = (state_q == DONE);
endmodule

// File: tb/tb_db15_serial_joy_reader.sv
// Directed bench for db15_serial_joy_reader with a behavioural 74HC165 adapter model.
module tb_db15_serial_joy_reader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    db15_serial_joy_reader #(.CLK_DIV(4), .POLL_TICKS(4), .FRAME_BITS(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .JOY_DATA   (JOY_DATA),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Adapter: parallel load on JOY_LOAD low, shift toward bit 0 on JOY_CLK rise, high fill.
    logic [23:0] frame_word = 24'hFFFFFF;
    logic [23:0] adp_sr = 24'hFFFFFF;
    always @(negedge JOY_LOAD) adp_sr = frame_word;
    always @(posedge JOY_CLK) adp_sr = {1'b1, adp_sr[23:1]};
    assign JOY_DATA = adp_sr[0];

    int rise_cnt = 0;
    int load_cnt = 0;
    int fd_cnt = 0;
    always @(posedge JOY_CLK) rise_cnt = rise_cnt + 1;
    always @(negedge JOY_LOAD) load_cnt = load_cnt + 1;
    always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Waits for frame_done, then one more negedge so the DONE update is visible.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_rises(input int target);
        int n;
        n = 0;
        while (rise_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rise_wait_timeout", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lo, hi, good, r0, f0, l0;
        reset_n    = 1'b0;
        en         = 1'b1;
        frame_word = 24'hFFFFFE;
        repeat (10) @(negedge clk);
        check("rst_load", 32'(JOY_LOAD), 32'd1);
        check("rst_clk", 32'(JOY_CLK), 32'd0);
        check("rst_j1", 32'(joystick1), 32'd0);
        check("rst_j2", 32'(joystick2), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);

        // First frame: load timing and clock pulse shape.
        r0 = rise_cnt;
        f0 = fd_cnt;
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (JOY_LOAD === 1'b1 && n < 100);
        check("load_delay", 32'(n), 32'd16);
        lo = 0;
        while (JOY_LOAD === 1'b0 && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        check("load_width", 32'(lo), 32'd4);
        good = 0;
        for (int i = 0; i < 24; i++) begin
            lo = 0;
            while (JOY_CLK === 1'b0 && lo < 20) begin
                lo++;
                @(negedge clk);
            end
            hi = 0;
            while (JOY_CLK === 1'b1 && hi < 20) begin
                hi++;
                @(negedge clk);
            end
            if (lo == 4 && hi == 4) good++;
        end
        check("pulse_shape", 32'(good), 32'd24);
        check("fd_high", 32'(frame_done), 32'd1);
        @(negedge clk);
        check("fd_low", 32'(frame_done), 32'd0);
        check("fd_once", 32'(fd_cnt - f0), 32'd1);
        check("rises_f1", 32'(rise_cnt - r0), 32'd24);
        check("f1_j1", 32'(joystick1), 32'd0);
        check("f1_j2", 32'(joystick2), 32'd0);

        wait_done("f2");
        check("f2_j1", 32'(joystick1), 32'h0001);
        check("f2_j2", 32'(joystick2), 32'h0000);

        // Single-frame glitch must not reach the outputs.
        frame_word = 24'h000000;
        wait_done("g1");
        check("g1_j1", 32'(joystick1), 32'h0001);
        frame_word = 24'hFFFFFE;
        wait_done("g2");
        check("g2_j1", 32'(joystick1), 32'h0001);
        wait_done("g3");
        check("g3_j1", 32'(joystick1), 32'h0001);

        // Player 2: bits 15 and 23 low.
        frame_word = 24'h7F7FFF;
        wait_done("p2a");
        check("p2a_j1", 32'(joystick1), 32'h0001);
        check("p2a_j2", 32'(joystick2), 32'h0000);
        wait_done("p2b");
        check("p2b_j1", 32'(joystick1), 32'h0000);
        check("p2b_j2", 32'(joystick2), 32'h0808);

        // Reset while in CLKHI at bit 10.
        frame_word = 24'hFFFFFE;
        wait_rises(rise_cnt + 11);
        check("mid_clkhi", 32'(JOY_CLK), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_clk", 32'(JOY_CLK), 32'd0);
        check("mid_rst_load", 32'(JOY_LOAD), 32'd1);
        check("mid_rst_j1", 32'(joystick1), 32'd0);
        check("mid_rst_j2", 32'(joystick2), 32'd0);
        repeat (3) @(negedge clk);
        f0 = fd_cnt;
        r0 = rise_cnt;
        reset_n = 1'b1;
        wait_done("pr1");
        check("pr1_j1", 32'(joystick1), 32'h0000);
        check("pr1_rises", 32'(rise_cnt - r0), 32'd24);
        wait_done("pr2");
        check("pr2_j1", 32'(joystick1), 32'h0001);
        check("pr2_j2", 32'(joystick2), 32'h0000);
        check("pr_fd", 32'(fd_cnt - f0), 32'd2);

        // Drop enable mid-frame.
        wait_rises(rise_cnt + 5);
        en = 1'b0;
        f0 = fd_cnt;
        wait_done("en_off");
        repeat (2) @(negedge clk);
        check("en_off_fd", 32'(fd_cnt - f0), 32'd1);
        check("en_off_j1", 32'(joystick1), 32'h0000);
        r0 = rise_cnt;
        l0 = load_cnt;
        f0 = fd_cnt;
        repeat (600) @(negedge clk);
        check("en_off_rises", 32'(rise_cnt - r0), 32'd0);
        check("en_off_loads", 32'(load_cnt - l0), 32'd0);
        check("en_off_fd2", 32'(fd_cnt - f0), 32'd0);
        check("en_off_loadhi", 32'(JOY_LOAD), 32'd1);
        en = 1'b1;
        wait_done("en_on1");
        check("en_on1_j1", 32'(joystick1), 32'h0000);
        wait_done("en_on2");
        check("en_on2_j1", 32'(joystick1), 32'h0001);
        check("en_on2_j2", 32'(joystick2), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
